dram_ctrl: RTL and testbench

- Memory-side consumer placed directly downstream of the DRAM request queue.
- Pops one request at a time and models a fixed-latency DRAM access on an internal word array.
- Pushes read responses into a downstream response queue.
- Serialises requests: at most one request in flight. Counts completed reads and writes.

---
 rtl/dram_ctrl.sv | 123 ++++++++++++
 tb/tb_dram_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// Fixed-latency DRAM model sitting between a request queue and a response queue.
// Serialises requests (one in flight), answers reads, counts completed reads/writes.
module dram_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int LATENCY       = 4,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_empty,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]   req_data,
  input  logic                             req_valid,
  output logic                             req_rd_en,
  input  logic                             resp_full,
  output logic                             resp_wr_en,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] resp_data,
  output logic                             busy,
  output logic [COUNTER_WIDTH-1:0]         rd_count,
  output logic [COUNTER_WIDTH-1:0]         wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_REQ = 3'd2,
    ACCESS   = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t                  state_r;
  logic                    op_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [LAT_W-1:0]        lat_r;
  logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];
  logic                    write_now_s;

  assign write_now_s = (state_r == ACCESS) && (lat_r == '0) && op_r;

  // Push is combinational on resp_full so a full queue stalls without losing a cycle.
  assign resp_wr_en = (state_r == RESP) && !resp_full;

  // Word array: intentionally not reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (write_now_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  // Control FSM, latched request, response register and statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      op_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      lat_r     <= '0;
      req_rd_en <= 1'b0;
      resp_data <= '0;
      busy      <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!req_empty) begin
            state_r   <= FETCH;
            req_rd_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          req_rd_en <= 1'b0;
          state_r   <= WAIT_REQ;
        end
        WAIT_REQ: begin
          if (req_valid) begin
            op_r    <= req_data[ADDR_WIDTH+DATA_WIDTH];
            addr_r  <= req_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            wdata_r <= req_data[DATA_WIDTH-1:0];
            lat_r   <= LAT_W'(LATENCY - 1);
            state_r <= ACCESS;
          end else begin
            // Missing read data: abandon the slot rather than stall forever.
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ACCESS: begin
          if (lat_r == '0) begin
            if (op_r) begin
              wr_count <= wr_count + COUNTER_WIDTH'(1);
              state_r  <= IDLE;
              busy     <= 1'b0;
            end else begin
              resp_data <= {addr_r, mem_r[addr_r]};
              state_r   <= RESP;
            end
          end else begin
            lat_r <= lat_r - LAT_W'(1);
          end
        end
        RESP: begin
          if (!resp_full) begin
            rd_count <= rd_count + COUNTER_WIDTH'(1);
            state_r  <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_rd_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: vector table for read/write traffic plus
// hand-written sequences for latency, back-pressure, reset and counter wrap.
module tb_dram_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int LAT = 4;
  localparam int CW  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_empty;
  logic [AW+DW:0]    req_data = '0;
  logic              req_valid = 1'b0;
  logic              req_rd_en;
  logic              resp_full;
  logic              resp_wr_en;
  logic [AW+DW-1:0]  resp_data;
  logic              busy;
  logic [CW-1:0]     rd_count;
  logic [CW-1:0]     wr_count;

  dram_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .req_empty(req_empty), .req_data(req_data),
    .req_valid(req_valid), .req_rd_en(req_rd_en), .resp_full(resp_full),
    .resp_wr_en(resp_wr_en), .resp_data(resp_data), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Request queue model: pushed by the test, popped one cycle after req_rd_en.
  logic [AW+DW:0] qmem [0:2047];
  int   push_cnt = 0;
  int   pop_cnt  = 0;
  logic pend = 1'b0;
  logic drop_valid = 1'b0;

  assign req_empty = (push_cnt == pop_cnt);

  always @(negedge clk) begin
    if (pend) begin
      req_data  = qmem[pop_cnt];
      req_valid = !drop_valid;
      pop_cnt   = pop_cnt + 1;
      pend      = 1'b0;
    end else begin
      req_valid = 1'b0;
    end
    if (req_rd_en) pend = 1'b1;
  end

  // Output monitor: pulse counts, last pushed response, handshake violations.
  int   rd_en_pulses = 0;
  int   resp_pulses  = 0;
  int   viol = 0;
  logic prev_rd_en = 1'b0;
  logic [AW+DW-1:0] last_resp = '0;

  always @(negedge clk) begin
    if (req_rd_en && resp_wr_en) begin
      viol = viol + 1;
      $display("FAIL overlap: req_rd_en and resp_wr_en both high at %0t", $time);
    end
    if (req_rd_en && prev_rd_en) begin
      viol = viol + 1;
      $display("FAIL double_pop: req_rd_en high two cycles running at %0t", $time);
    end
    if (req_rd_en) rd_en_pulses = rd_en_pulses + 1;
    if (resp_wr_en) begin
      resp_pulses = resp_pulses + 1;
      last_resp   = resp_data;
    end
    prev_rd_en = req_rd_en;
  end

  typedef struct {
    logic        op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];
  int   exp_rd = 0;
  int   exp_wr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic op, input logic [7:0] a, input logic [31:0] d);
    qmem[push_cnt] = {op, a, d};
    push_cnt = push_cnt + 1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    while (busy && n < 80) begin @(negedge clk); n++; end
    check({name, "_timeout"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic do_read(input string name, input logic [7:0] a, input logic [31:0] exp);
    int r0;
    @(posedge clk); #1;
    r0 = resp_pulses;
    push(1'b0, a, 32'd0);
    wait_done(name);
    @(negedge clk);
    exp_rd++;
    check({name, "_npush"}, 64'(resp_pulses), 64'(r0 + 1));
    check({name, "_data"}, 64'(last_resp), 64'({a, exp}));
  endtask

  logic rd_s [10];
  logic wr_s [10];
  logic bz_s [10];

  initial begin
    int r0;
    int rp0;
    int n;

    vecs[0] = '{1'b1, 8'h05, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 8'h05, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 8'h00, 32'h00000001, 32'h0};
    vecs[3] = '{1'b1, 8'hFF, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{1'b0, 8'h00, 32'h0,        32'h00000001};
    vecs[5] = '{1'b0, 8'hFF, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b1, 8'hFF, 32'h12345678, 32'h0};
    vecs[7] = '{1'b0, 8'hFF, 32'h0,        32'h12345678};
    vecs[8] = '{1'b1, 8'h10, 32'h00000001, 32'h0};

    resp_full = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_rd_en", 64'(req_rd_en), 64'd0);
    check("rst_wr_en", 64'(resp_wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Table-driven read/write traffic.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].op) begin
        @(posedge clk); #1;
        r0 = resp_pulses;
        push(1'b1, vecs[i].addr, vecs[i].wdata);
        wait_done("vec_wr");
        @(negedge clk);
        exp_wr++;
        check("vec_wr_noresp", 64'(resp_pulses), 64'(r0));
      end else begin
        do_read("vec_rd", vecs[i].addr, vecs[i].exp_rdata);
      end
    end
    check("vec_rd_count", 64'(rd_count), 64'(exp_rd));
    check("vec_wr_count", 64'(wr_count), 64'(exp_wr));

    // Exact cycle timing of a single read.
    @(posedge clk); #1;
    push(1'b0, 8'h05, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rd_s[k] = req_rd_en; wr_s[k] = resp_wr_en; bz_s[k] = busy;
    end
    exp_rd++;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("lat_rd_en_%0d", k), 64'(rd_s[k]), 64'(k == 1));
      check($sformatf("lat_wr_en_%0d", k), 64'(wr_s[k]), 64'(k == 1 + 2 + LAT));
      check($sformatf("lat_busy_%0d", k), 64'(bz_s[k]), 64'(k >= 1 && k <= 3 + LAT));
    end
    check("lat_data", 64'(last_resp), 64'({8'h05, 32'hDEADBEEF}));

    // Back-pressure: response queue full for the first three RESP cycles.
    resp_full = 1'b1;
    @(posedge clk); #1;
    r0 = resp_pulses;
    push(1'b0, 8'hFF, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 7) begin
        check("bp_hold_wr_en", 64'(resp_wr_en), 64'd0);
        check("bp_hold_data", 64'(resp_data), 64'({8'hFF, 32'h12345678}));
      end
    end
    @(posedge clk); #1;
    resp_full = 1'b0;
    @(negedge clk);
    check("bp_push", 64'(resp_wr_en), 64'd1);
    @(negedge clk);
    exp_rd++;
    check("bp_push_end", 64'(resp_wr_en), 64'd0);
    check("bp_npush", 64'(resp_pulses), 64'(r0 + 1));
    check("bp_rd_count", 64'(rd_count), 64'(exp_rd));

    // Empty queue: controller must stay quiet.
    r0 = rd_en_pulses;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_outputs", {61'd0, req_rd_en, resp_wr_en, busy}, 64'd0);
    end
    check("idle_pops", 64'(rd_en_pulses), 64'(r0));
    check("idle_rd_count", 64'(rd_count), 64'(exp_rd));
    check("idle_wr_count", 64'(wr_count), 64'(exp_wr));

    // Missing req_valid: request is dropped with no side effects.
    drop_valid = 1'b1;
    @(posedge clk); #1;
    r0 = resp_pulses;
    push(1'b0, 8'h05, 32'd0);
    wait_done("noval");
    drop_valid = 1'b0;
    @(negedge clk);
    check("noval_noresp", 64'(resp_pulses), 64'(r0));
    check("noval_rd_count", 64'(rd_count), 64'(exp_rd));

    // Asynchronous reset in the middle of a write's ACCESS phase.
    @(posedge clk); #1;
    push(1'b1, 8'h10, 32'hFFFF0000);
    for (int k = 0; k < 5; k++) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_rd = 0; exp_wr = 0;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rd_en", 64'(req_rd_en), 64'd0);
    check("arst_resp_data", 64'(resp_data), 64'd0);
    check("arst_rd_count", 64'(rd_count), 64'd0);
    check("arst_wr_count", 64'(wr_count), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    do_read("arst_readback", 8'h10, 32'h00000001);
    check("arst_rd_count_after", 64'(rd_count), 64'd1);
    check("arst_wr_count_after", 64'(wr_count), 64'd0);

    // Back-to-back writes from a pre-filled queue, through counter wrap.
    @(posedge clk); #1;
    rp0 = rd_en_pulses;
    for (int i = 0; i < 1023; i++) push(1'b1, 8'(i), 32'(i));
    n = 0;
    while ((pop_cnt != push_cnt || busy) && n < 9000) begin @(negedge clk); n++; end
    check("wrap_timeout", 64'(n < 9000), 64'd1);
    check("wrap_1023", 64'(wr_count), 64'd1023);
    @(posedge clk); #1;
    push(1'b1, 8'hFF, 32'd1023);
    wait_done("wrap_last");
    check("wrap_zero", 64'(wr_count), 64'd0);
    check("wrap_pops", 64'(rd_en_pulses - rp0), 64'd1024);
    do_read("wrap_rd10", 8'h10, 32'h00000310);
    do_read("wrap_rdff", 8'hFF, 32'h000003FF);
    check("handshake_viol", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
